activation_skew_feeder: RTL and testbench

//  West-edge feeder for the systolic PE array. Accepts one ROWS-wide activation vector per beat (valid/ready).

---
 rtl/activation_skew_feeder_pkg.sv | 20 ++
 rtl/activation_skew_feeder_if.sv | 26 ++
 rtl/activation_skew_feeder_skew_shift.sv | 37 +++
 rtl/activation_skew_feeder.sv | 148 ++++++++++++++
 tb/tb_activation_skew_feeder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/activation_skew_feeder_pkg.sv
// Shared types and helpers for the activation skew feeder.
package act_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One extra bit keeps the counter legal (at least 1 bit wide) when rows is 1.
    function automatic int drain_cnt_width(input int rows);
        return $clog2(rows) + 1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/activation_skew_feeder_if.sv
// Upstream valid/ready stream carrying one ROWS-wide activation vector per beat.
interface activation_skew_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4
);

    logic                       s_valid_i;
    logic                       s_ready_o;
    logic [ROWS*DATA_WIDTH-1:0] s_data_i;
    logic                       s_last_i;

    modport master (
        output s_valid_i,
        output s_data_i,
        output s_last_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  s_last_i,
        output s_ready_o
    );

endinterface

// File: rtl/activation_skew_feeder_skew_shift.sv
// DELAY-deep register chain with synchronous active-high reset; DELAY=0 is a plain wire.
module skew_shift #(
    parameter int WIDTH = 18,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DELAY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/activation_skew_feeder.sv
// West-edge feeder: registers each accepted beat, then skews row r by r extra cycles.
// Build with ACT_FEED_PERF_EN defined to add per-tile beat/bubble counters.
module activation_skew_feeder
    import act_feed_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    activation_skew_feeder_if.slave    s,
    output logic [ROWS*DATA_WIDTH-1:0] act_o,
    output logic [ROWS-1:0]            act_en_o,
    output logic [ROWS-1:0]            end_o,
    output logic                       busy_o,
    output logic                       done_o
`ifdef ACT_FEED_PERF_EN
    ,
    output logic [31:0]                beat_cnt_o,
    output logic [31:0]                bubble_cnt_o
`endif
);

    localparam int               CNT_W      = drain_cnt_width(ROWS);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(ROWS - 1);

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          drain_cnt;
    logic [CNT_W-1:0]          drain_cnt_next;
    logic                      accept;

    logic [ROWS*DATA_WIDTH-1:0] stage_data;
    logic                       stage_en;
    logic                       stage_end;

    assign accept = s.s_valid_i && s.s_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // DRAIN spans ROWS cycles so DONE lands one cycle after the deepest row shows END.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s.s_last_i) begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept && s.s_last_i) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        s.s_ready_o = !rst && ((state == IDLE) || (state == STREAM));
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
    end

    // Non-accepted cycles load a zero bubble so enables never outrun real data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data <= '0;
            stage_en   <= 1'b0;
            stage_end  <= 1'b0;
        end else begin
            stage_data <= accept ? s.s_data_i : '0;
            stage_en   <= accept;
            stage_end  <= accept && s.s_last_i;
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            logic [DATA_WIDTH+1:0] row_q;

            skew_shift #(
                .WIDTH (DATA_WIDTH + 2),
                .DELAY (r)
            ) u_skew (
                .clk (clk),
                .rst (rst),
                .d   ({stage_end, stage_en, stage_data[r*DATA_WIDTH +: DATA_WIDTH]}),
                .q   (row_q)
            );

            assign act_o[r*DATA_WIDTH +: DATA_WIDTH] = row_q[DATA_WIDTH-1:0];
            assign act_en_o[r]                       = row_q[DATA_WIDTH];
            assign end_o[r]                          = row_q[DATA_WIDTH+1];
        end
    endgenerate

`ifdef ACT_FEED_PERF_EN
    logic tile_start;

    assign tile_start = (state == IDLE) && accept;

    // The starting beat counts itself; counters then hold through DONE until the next tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_o   <= '0;
            bubble_cnt_o <= '0;
        end else if (tile_start) begin
            beat_cnt_o   <= 32'd1;
            bubble_cnt_o <= '0;
        end else if (state == STREAM) begin
            if (accept) begin
                beat_cnt_o <= sat_inc32(beat_cnt_o);
            end else begin
                bubble_cnt_o <= sat_inc32(bubble_cnt_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Scoreboard bench for activation_skew_feeder; perf counters are checked when ACT_FEED_PERF_EN is defined.
module tb_activation_skew_feeder;

    localparam int DATA_WIDTH = 16;
    localparam int ROWS       = 4;
    localparam int BUS        = ROWS * DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    activation_skew_feeder_if #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS)) sif ();

    logic [BUS-1:0]  act_o;
    logic [ROWS-1:0] act_en_o;
    logic [ROWS-1:0] end_o;
    logic            busy_o;
    logic            done_o;
`ifdef ACT_FEED_PERF_EN
    logic [31:0]     beat_cnt_o;
    logic [31:0]     bubble_cnt_o;
`endif

    activation_skew_feeder #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (sif),
        .act_o        (act_o),
        .act_en_o     (act_en_o),
        .end_o        (end_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef ACT_FEED_PERF_EN
        ,
        .beat_cnt_o   (beat_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    typedef struct {
        int                    due;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } exp_t;

    exp_t rowQ [ROWS][$];

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int lastAt      = -100;
    int doneCount   = 0;
    bit inTile      = 1'b0;
    bit modelAccept = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Timing model: cycle c's inputs and outputs are both stable at the falling edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit   readyExp;
            bit   busyExp;
            bit   doneExp;
            bit   acc;
            bit   expEn;
            exp_t item;

            readyExp = !rst && !(cyc >= lastAt + 1 && cyc <= lastAt + ROWS + 1);
            busyExp  = inTile;
            doneExp  = (cyc == lastAt + ROWS + 1);

            checkOutput("s_ready", sif.s_ready_o, readyExp);
            checkOutput("busy", busy_o, busyExp);
            checkOutput("done", done_o, doneExp);

            for (int r = 0; r < ROWS; r++) begin
                while (rowQ[r].size() > 0 && rowQ[r][0].due < cyc) item = rowQ[r].pop_front();
                expEn = (rowQ[r].size() > 0) && (rowQ[r][0].due == cyc);
                checkOutput($sformatf("row%0d_en", r), act_en_o[r], expEn);
                if (expEn) begin
                    item = rowQ[r].pop_front();
                    checkOutput($sformatf("row%0d_data", r), act_o[r*DATA_WIDTH +: DATA_WIDTH], item.data);
                    checkOutput($sformatf("row%0d_end", r), end_o[r], item.last);
                end else begin
                    checkOutput($sformatf("row%0d_bubble_data", r), act_o[r*DATA_WIDTH +: DATA_WIDTH], 0);
                    checkOutput($sformatf("row%0d_bubble_end", r), end_o[r], 0);
                end
            end

            acc         = readyExp && sif.s_valid_i;
            modelAccept = acc;
            if (acc) begin
                inTile = 1'b1;
                for (int r = 0; r < ROWS; r++) begin
                    item.due  = cyc + 1 + r;
                    item.data = sif.s_data_i[r*DATA_WIDTH +: DATA_WIDTH];
                    item.last = sif.s_last_i;
                    rowQ[r].push_back(item);
                end
                if (sif.s_last_i) lastAt = cyc;
            end
            if (doneExp) begin
                inTile = 1'b0;
                doneCount++;
            end
            if (rst) begin
                for (int r = 0; r < ROWS; r++) rowQ[r].delete();
                lastAt = -100;
                inTile = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [BUS-1:0] d, input logic l);
        sif.s_valid_i = v;
        sif.s_data_i  = d;
        sif.s_last_i  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBeat(input logic l);
        logic [BUS-1:0] d;
        int             tries;
        d     = {$urandom, $urandom};
        tries = 0;
        do begin
            applyStimulus(1'b1, d, l);
            tries++;
        end while (!modelAccept && tries < 40);
        if (!modelAccept) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, {$urandom, $urandom}, 1'b0);
    endtask

    task automatic waitTileEnd();
        int startCount;
        int k;
        startCount = doneCount;
        k          = 0;
        while (doneCount == startCount && k < 50) begin
            applyStimulus(1'b0, {$urandom, $urandom}, 1'b0);
            k++;
        end
        if (doneCount == startCount) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic threeBeatTile();
        sendBeat(1'b0);
        sendBeat(1'b0);
        sendBeat(1'b1);
        waitTileEnd();
    endtask

    initial begin
        sif.s_valid_i = 1'b0;
        sif.s_data_i  = '0;
        sif.s_last_i  = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] three back-to-back beats");
        threeBeatTile();
        idleCycles(2);

        $display("[TB] valid gap between two beats");
        sendBeat(1'b0);
        idleCycles(1);
        sendBeat(1'b1);
        waitTileEnd();
        idleCycles(2);

        $display("[TB] single last beat from idle");
        sendBeat(1'b1);
        waitTileEnd();
        idleCycles(2);

        $display("[TB] reset in the middle of a tile");
        sendBeat(1'b0);
        sendBeat(1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        rst = 1'b0;
        idleCycles(8);
        threeBeatTile();
        idleCycles(2);

        $display("[TB] valid held across tile boundary");
        sendBeat(1'b0);
        sendBeat(1'b0);
        sendBeat(1'b1);
        sendBeat(1'b0);
        sendBeat(1'b1);
        waitTileEnd();
        idleCycles(2);

`ifdef ACT_FEED_PERF_EN
        $display("[TB] perf counters with two bubbles");
        sendBeat(1'b0);
        sendBeat(1'b0);
        idleCycles(1);
        sendBeat(1'b0);
        idleCycles(1);
        sendBeat(1'b0);
        sendBeat(1'b1);
        waitTileEnd();
        idleCycles(2);
        checkOutput("beat_cnt", beat_cnt_o, 5);
        checkOutput("bubble_cnt", bubble_cnt_o, 2);
`endif

        idleCycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
